uart_handshake_responder: RTL and testbench
===========================================

Name: uart_handshake_responder

Overview:
Peer-side responder for the UART handshake protocol. It sits between a byte-level uart_rx/uart_tx pair and user logic on the remote board. It answers the initiator's request byte with ACK, waits for a confirm byte under a timeout, and latches ESTABLISHED or FAILED. Once established it passes bytes through in both directions and drives a 4-bit code (E/F) for the 7-segment decoder.

Parameters:
CLKS_TIMEOUT, 50_000_000, clock cycles allowed in WAIT_CONF (1 s at 50 MHz).
MAX_TRIES, 3, number of failed attempts before FAILED is latched.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
i_Rx_DV  in  1  one-cycle strobe from uart_rx, byte valid
i_Rx_Byte  in  8  byte from uart_rx
i_Tx_Active  in  1  uart_tx busy
i_Tx_Done  in  1  uart_tx one-cycle done strobe
o_Tx_DV  out  1  one-cycle strobe to uart_tx
o_Tx_Byte  out  8  byte to uart_tx
i_User_DV  in  1  user transmit request
i_User_Byte  in  8  user transmit byte
o_User_Ready  out  1  user request will be accepted this cycle
o_Data_DV  out  1  received payload byte valid, one cycle
o_Data_Byte  out  8  received payload byte
o_Established  out  1  handshake complete
o_Fail  out  1  handshake failed, latched
o_Code  out  4  0x0 during handshake, 0xE when established, 0xF when failed

Behaviour:
- Single clock domain. Reset is synchronous and active-high, one clock. Ports are named clock and reset.
- Reset values: all outputs 0; state IDLE; tries=0; timer=0. Reset asserted mid-operation aborts everything; o_Tx_DV is never asserted during reset.
- Protocol bytes: REQ=0x16, ACK=0x06, NAK=0x15, CONF=0x55.
- States: IDLE, SEND_ACK, WAIT_ACK, WAIT_CONF, SEND_NAK, WAIT_NAK, ESTABLISHED, FAILED.
- IDLE:
  - Rx byte == REQ -> SEND_ACK.
  - Any other byte is ignored (line noise); tries is unchanged.
- SEND_ACK / SEND_NAK:
  - When !i_Tx_Active, pulse o_Tx_DV for exactly 1 cycle with ACK or NAK, then go to WAIT_ACK / WAIT_NAK.
  - Otherwise stall.
- WAIT_ACK: i_Tx_Done -> WAIT_CONF; timer cleared on entry.
- WAIT_NAK: i_Tx_Done -> IDLE.
- WAIT_CONF: timer increments every cycle.
  - Rx CONF -> ESTABLISHED.
  - Rx REQ -> tries++, then SEND_ACK (retransmission).
  - Rx other byte -> tries++, then SEND_NAK.
  - Timer reaches CLKS_TIMEOUT-1 with no byte -> tries++, then IDLE. Timeout fires after exactly CLKS_TIMEOUT cycles in the state.
  - A byte and the timeout in the same cycle: the byte wins.
- Any tries++ that reaches MAX_TRIES goes to FAILED instead of the listed target; no NAK is sent.
- Bytes received in states other than IDLE and WAIT_CONF are discarded.
- ESTABLISHED:
  - o_Established=1, o_Code=0xE.
  - Every i_Rx_DV produces o_Data_DV and o_Data_Byte exactly 1 cycle later. REQ/CONF values are payload here; there is no re-handshake.
  - o_User_Ready = !i_Tx_Active && !tx_pend. tx_pend is set on accept and cleared on i_Tx_Done.
  - i_User_DV while ready: o_Tx_DV pulses next cycle with the captured byte.
  - i_User_DV while not ready: dropped, no effect.
- FAILED: o_Fail=1, o_Code=0xF, all strobes 0, o_User_Ready=0. Held until reset.
- Outside ESTABLISHED, o_User_Ready=0 and o_Data_DV=0.
- Timer width is $clog2(CLKS_TIMEOUT); it is saturation-free because it is cleared on every entry to WAIT_CONF. tries width is $clog2(MAX_TRIES+1).
- o_Tx_DV is never asserted while i_Tx_Active=1.

Decomposition:
- Package uart_hs_pkg holds:
  - state enum hs_state_t;
  - byte constants HS_REQ, HS_ACK, HS_NAK, HS_CONF;
  - code constants HS_CODE_IDLE=4'h0, HS_CODE_OK=4'hE, HS_CODE_FAIL=4'hF.
- One natural sub-module, hs_timeout_counter: clear/enable/expire with CLKS_TIMEOUT parameter, one-cycle expire pulse.

Test Plan:
All scenarios use CLKS_TIMEOUT=100, MAX_TRIES=3.
- Reset: hold reset 3 cycles -> all outputs 0, o_Code=0x0. Drive REQ during reset -> no o_Tx_DV.
- Happy path: REQ -> o_Tx_DV once with 0x06. Tx_Done, then CONF at cycle 50 -> o_Established=1, o_Code=0xE.
- Timeout: REQ, ACK done, no byte for 100 cycles -> back to IDLE, tries=1. Repeat 2 more times -> o_Fail=1, o_Code=0xF. A further REQ gets no response.
- Bad confirm: REQ, ACK, then 0x33 -> o_Tx_DV with 0x15, then IDLE. Next REQ/CONF -> established.
- Boundary: CONF arriving on the same cycle the timer expires -> ESTABLISHED, not a timeout.
- Data path, established:
  - Rx 0xA7 -> o_Data_DV with 0xA7 exactly 1 cycle later.
  - User_DV 0x3C while ready -> o_Tx_DV 0x3C next cycle, ready low until Tx_Done.
  - Second User_DV while busy -> dropped.

Source files
------------

// File: rtl/uart_hs_pkg.sv
// Shared types and constants for the UART handshake responder: FSM states,
// protocol byte values and the 7-segment status codes.
package uart_hs_pkg;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_SEND_ACK,
        HS_WAIT_ACK,
        HS_WAIT_CONF,
        HS_SEND_NAK,
        HS_WAIT_NAK,
        HS_ESTABLISHED,
        HS_FAILED
    } hs_state_t;

    localparam logic [7:0] HS_REQ  = 8'h16;
    localparam logic [7:0] HS_ACK  = 8'h06;
    localparam logic [7:0] HS_NAK  = 8'h15;
    localparam logic [7:0] HS_CONF = 8'h55;

    localparam logic [3:0] HS_CODE_IDLE = 4'h0;
    localparam logic [3:0] HS_CODE_OK   = 4'hE;
    localparam logic [3:0] HS_CODE_FAIL = 4'hF;

endpackage

// File: rtl/hs_timeout_counter.sv
// Confirm-window timer: cleared on entry, counts while enabled, and flags
// expiry during the CLKS_TIMEOUT-th enabled cycle.
module hs_timeout_counter #(
    parameter int CLKS_TIMEOUT = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (CLKS_TIMEOUT > 1) ? $clog2(CLKS_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_TIMEOUT - 1);

    logic [W-1:0] count;

    // No saturation needed: the owner clears the count on every window entry.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_handshake_responder.sv
// Peer-side handshake responder: ACKs a REQ, waits for CONF under a timeout,
// then bridges payload bytes between uart_rx/uart_tx and user logic.
module uart_handshake_responder
    import uart_hs_pkg::*;
#(
    parameter int CLKS_TIMEOUT = 50_000_000,
    parameter int MAX_TRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_User_DV,
    input  logic [7:0] i_User_Byte,
    output logic       o_User_Ready,
    output logic       o_Data_DV,
    output logic [7:0] o_Data_Byte,
    output logic       o_Established,
    output logic       o_Fail,
    output logic [3:0] o_Code
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    hs_state_t     state, state_nxt;
    logic [TW-1:0] tries, tries_next;
    logic          tries_inc, timer_clear, timer_expire, hs_send;
    logic          est, accept, tx_pend, user_fire;
    logic [7:0]    user_byte, data_byte;
    logic          data_dv;

    hs_timeout_counter #(.CLKS_TIMEOUT(CLKS_TIMEOUT)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (state == HS_WAIT_CONF),
        .expire (timer_expire)
    );

    assign tries_next = tries + 1'b1;

    always_comb begin
        state_nxt   = state;
        tries_inc   = 1'b0;
        timer_clear = 1'b0;
        hs_send     = 1'b0;
        case (state)
            HS_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == HS_REQ) state_nxt = HS_SEND_ACK;
            end
            HS_SEND_ACK: begin
                if (!i_Tx_Active) begin
                    hs_send   = 1'b1;
                    state_nxt = HS_WAIT_ACK;
                end
            end
            HS_WAIT_ACK: begin
                if (i_Tx_Done) begin
                    timer_clear = 1'b1;
                    state_nxt   = HS_WAIT_CONF;
                end
            end
            HS_WAIT_CONF: begin
                // A received byte takes priority over a coincident expiry.
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == HS_CONF) begin
                        state_nxt = HS_ESTABLISHED;
                    end else begin
                        tries_inc = 1'b1;
                        state_nxt = (i_Rx_Byte == HS_REQ) ? HS_SEND_ACK : HS_SEND_NAK;
                    end
                end else if (timer_expire) begin
                    tries_inc = 1'b1;
                    state_nxt = HS_IDLE;
                end
                if (tries_inc && tries_next == TW'(MAX_TRIES)) state_nxt = HS_FAILED;
            end
            HS_SEND_NAK: begin
                if (!i_Tx_Active) begin
                    hs_send   = 1'b1;
                    state_nxt = HS_WAIT_NAK;
                end
            end
            HS_WAIT_NAK: begin
                if (i_Tx_Done) state_nxt = HS_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HS_IDLE;
            tries <= '0;
        end else begin
            state <= state_nxt;
            if (tries_inc) tries <= tries_next;
        end
    end

    assign est    = (state == HS_ESTABLISHED);
    assign accept = o_User_Ready && i_User_DV;

    // Established data path: user bytes go out the cycle after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_pend   <= 1'b0;
            user_fire <= 1'b0;
            user_byte <= '0;
            data_dv   <= 1'b0;
            data_byte <= '0;
        end else begin
            user_fire <= accept;
            if (accept) begin
                user_byte <= i_User_Byte;
                tx_pend   <= 1'b1;
            end else if (i_Tx_Done) begin
                tx_pend <= 1'b0;
            end
            data_dv <= est && i_Rx_DV;
            if (est && i_Rx_DV) data_byte <= i_Rx_Byte;
        end
    end

    assign o_User_Ready  = est && !i_Tx_Active && !tx_pend;
    assign o_Tx_DV       = !reset && (hs_send || user_fire);
    assign o_Tx_Byte     = hs_send   ? ((state == HS_SEND_NAK) ? HS_NAK : HS_ACK) :
                           user_fire ? user_byte : 8'h00;
    assign o_Data_DV     = data_dv;
    assign o_Data_Byte   = data_byte;
    assign o_Established = est;
    assign o_Fail        = (state == HS_FAILED);

    always_comb begin
        o_Code = HS_CODE_IDLE;
        if (est) o_Code = HS_CODE_OK;
        else if (state == HS_FAILED) o_Code = HS_CODE_FAIL;
    end

endmodule

// File: tb/tb_uart_handshake_responder.sv
// Directed/randomized bench for uart_handshake_responder with a uart_tx stand-in
// and an outcome-level model (failure count, established flag).
module tb_uart_handshake_responder;
    import uart_hs_pkg::*;

    localparam int TO = 100;
    localparam int MT = 3;

    logic       clock = 1'b0, reset = 1'b1;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       emu_active = 1'b0, hold_busy = 1'b0, tx_done = 1'b0;
    logic       user_dv = 1'b0;
    logic [7:0] user_byte = 8'h00;
    logic       tx_active;
    logic       tx_dv, user_ready, data_dv, est, fail;
    logic [7:0] tx_byte, data_byte;
    logic [3:0] code;

    assign tx_active = emu_active | hold_busy;

    uart_handshake_responder #(.CLKS_TIMEOUT(TO), .MAX_TRIES(MT)) dut (
        .clock(clock), .reset(reset),
        .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_User_DV(user_dv), .i_User_Byte(user_byte), .o_User_Ready(user_ready),
        .o_Data_DV(data_dv), .o_Data_Byte(data_byte),
        .o_Established(est), .o_Fail(fail), .o_Code(code)
    );

    always #5 clock = ~clock;

    int cyc = 0, tx_pulses = 0, viol = 0, done_cyc = 0;
    int n_checks = 0, n_pass = 0, n_fail = 0;
    bit emu_busy = 1'b0;
    logic [7:0] tx_log[$];
    int m_fails = 0;
    bit m_est = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (tx_dv) begin
            tx_pulses <= tx_pulses + 1;
            if (tx_active) viol <= viol + 1;
        end
    end

    // uart_tx stand-in: goes busy after each strobe, then pulses done.
    initial forever begin
        @(negedge clock);
        if (tx_dv) begin
            tx_log.push_back(tx_byte);
            emu_busy = 1'b1;
            @(posedge clock); #1 emu_active = 1'b1;
            repeat ($urandom_range(2, 5)) @(posedge clock);
            #1 emu_active = 1'b0; tx_done = 1'b1;
            @(posedge clock); #1 tx_done = 1'b0; done_cyc = cyc; emu_busy = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock); #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_code();
        if (m_fails >= MT) return 4'hF;
        if (m_est) return 4'hE;
        return 4'h0;
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "/est"}, 32'(est), 32'(m_est && m_fails < MT));
        chk({tag, "/fail"}, 32'(fail), 32'(m_fails >= MT));
        chk({tag, "/code"}, 32'(code), 32'(exp_code()));
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        tick();
        rx_dv = 1'b0;
    endtask

    task automatic get_tx(input string tag, input logic [7:0] exp);
        logic [7:0] b = 8'h00;
        bit got = 1'b0;
        for (int i = 0; i < 40 && tx_log.size() == 0; i++) tick();
        if (tx_log.size() > 0) begin
            b = tx_log.pop_front();
            got = 1'b1;
        end
        chk(tag, {23'd0, got, b}, {23'd0, 1'b1, exp});
        for (int i = 0; i < 40 && emu_busy; i++) tick();
        chk({tag, "/done"}, 32'(emu_busy), 32'd0);
    endtask

    // Drive a byte during cycle k of the confirm window (cycle 0 follows tx done).
    task automatic send_at(input int k, input logic [7:0] b);
        while (cyc < done_cyc + k) tick();
        send_rx(b);
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_dv = 1'b0; user_dv = 1'b0; hold_busy = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 20 && emu_busy; i++) tick();
        tx_log.delete();
        m_fails = 0; m_est = 1'b0;
    endtask

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == HS_CONF || b == HS_REQ);
        return b;
    endfunction

    initial begin
        int p0;
        logic [7:0] b;
        logic [7:0] payload[4];

        // Reset held 3 cycles with a REQ on the line
        rx_dv = 1'b1; rx_byte = HS_REQ;
        repeat (3) tick();
        rx_dv = 1'b0; reset = 1'b0;
        chk("rst/tx_dv", 32'(tx_dv), 0);
        chk("rst/tx_byte", 32'(tx_byte), 0);
        chk("rst/ready", 32'(user_ready), 0);
        chk("rst/data_dv", 32'(data_dv), 0);
        chk("rst/data_byte", 32'(data_byte), 0);
        chk("rst/pulses", 32'(tx_pulses), 0);
        check_status("rst");

        // Line noise in IDLE is ignored
        p0 = tx_pulses;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == HS_REQ) b = 8'h00;
            send_rx(b);
        end
        repeat (5) tick();
        chk("noise/no_tx", 32'(tx_pulses - p0), 0);

        // Three timeouts latch FAILED; a CONF just after each window is ignored
        for (int t = 0; t < MT; t++) begin
            send_rx(HS_REQ);
            get_tx("to/ack", HS_ACK);
            send_at(TO, HS_CONF);
            m_fails++;
            repeat (3) tick();
            check_status("timeout");
        end
        p0 = tx_pulses;
        send_rx(HS_REQ);
        user_dv = 1'b1; user_byte = 8'h5A;
        tick();
        user_dv = 1'b0;
        repeat (20) tick();
        chk("failed/no_tx", 32'(tx_pulses - p0), 0);
        chk("failed/ready", 32'(user_ready), 0);

        // Retransmitted REQ, then bad confirm -> NAK, then success
        do_reset();
        send_rx(HS_REQ);
        get_tx("bc/ack", HS_ACK);
        send_at($urandom_range(0, 98), HS_REQ);
        m_fails++;
        get_tx("bc/retx_ack", HS_ACK);
        send_at($urandom_range(0, 98), bad_byte());
        m_fails++;
        get_tx("bc/nak", HS_NAK);
        check_status("bc/after_nak");
        send_rx(HS_REQ);
        get_tx("bc/ack2", HS_ACK);
        send_at($urandom_range(0, 99), HS_CONF);
        m_est = 1'b1;
        check_status("bc/est");

        // Repeated bad confirms: the final one goes to FAILED without a NAK
        do_reset();
        for (int t = 0; t < MT; t++) begin
            send_rx(HS_REQ);
            get_tx("bad/ack", HS_ACK);
            p0 = tx_pulses;
            send_at($urandom_range(0, 99), bad_byte());
            m_fails++;
            if (m_fails < MT) get_tx("bad/nak", HS_NAK);
            else begin
                repeat (10) tick();
                chk("bad/nak_suppressed", 32'(tx_pulses - p0), 0);
            end
        end
        check_status("bad/fail");

        // Happy path with ACK stalled by a busy transmitter
        do_reset();
        hold_busy = 1'b1;
        p0 = tx_pulses;
        send_rx(HS_REQ);
        repeat (5) tick();
        chk("stall/no_tx", 32'(tx_pulses - p0), 0);
        hold_busy = 1'b0;
        get_tx("happy/ack", HS_ACK);
        chk("happy/ack_once", 32'(tx_pulses - p0), 1);
        send_at(50, HS_CONF);
        m_est = 1'b1;
        check_status("happy");

        // Payload receive, including protocol values as plain data
        payload[0] = 8'hA7; payload[1] = HS_REQ; payload[2] = HS_CONF;
        payload[3] = 8'($urandom_range(0, 255));
        p0 = tx_pulses;
        for (int i = 0; i < 4; i++) begin
            rx_dv = 1'b1; rx_byte = payload[i];
            #1 chk("data/pre", 32'(data_dv), 0);
            tick();
            rx_dv = 1'b0;
            chk("data/dv", 32'(data_dv), 1);
            chk("data/byte", 32'(data_byte), 32'(payload[i]));
            tick();
            chk("data/dv_low", 32'(data_dv), 0);
        end
        chk("data/no_tx", 32'(tx_pulses - p0), 0);
        check_status("data");

        // User transmit; a second request while busy is dropped
        chk("user/ready", 32'(user_ready), 1);
        b = 8'($urandom_range(0, 255));
        p0 = tx_pulses;
        user_dv = 1'b1; user_byte = b;
        tick();
        user_dv = 1'b0;
        chk("user/tx_dv", 32'(tx_dv), 1);
        chk("user/tx_byte", 32'(tx_byte), 32'(b));
        chk("user/ready_low", 32'(user_ready), 0);
        tick();
        user_dv = 1'b1; user_byte = ~b;
        tick();
        user_dv = 1'b0;
        get_tx("user/log", b);
        repeat (3) tick();
        chk("user/dropped", 32'(tx_pulses - p0), 1);
        chk("user/ready_again", 32'(user_ready), 1);

        // Reset aborts ESTABLISHED; CONF on the expiry cycle still wins
        do_reset();
        check_status("abort");
        send_rx(HS_REQ);
        get_tx("bnd/ack", HS_ACK);
        send_at(TO - 1, HS_CONF);
        m_est = 1'b1;
        check_status("boundary");

        chk("tx_while_busy", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
